rtc_clock_core: RTL and testbench
=================================

RTC_CLOCK_CORE -- requirements
Module: rtc_clock_core

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50_000_000, clk cycles per 1 s tick (>=2).
REQ-002 SHALL have parameter HOUR_24, default 1; 1 = 00..23 hours, 0 = 01..12 hours with pm flag.
REQ-003 SHALL have parameter ALARM_SECS, default 30, alarm ring duration in seconds (1..59).
REQ-004 SHALL have port clk  in  1  sole clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports key_mode, key_inc_h, key_inc_m  in  1 each  debounced single-cycle key pulses.
REQ-007 SHALL have ports sec_bcd, min_bcd, hour_bcd  out  8 each  {tens,ones} BCD digits.
REQ-008 SHALL have ports pm  out  1  (0 when HOUR_24=1); tick_1hz  out  1  one-cycle tick pulse.
REQ-009 SHALL have port state  out  3  current FSM state code; alarm_on  out  1  alarm ringing.

Function
REQ-010 SHALL run a prescaler 0..CLK_DIV-1; tick_1hz is high for the one cycle when count==CLK_DIV-1.
REQ-011 SHALL use FSM states RUN(0), SET_H(1), SET_M(2), SET_AH(3), SET_AM(4); key_mode advances RUN->SET_H->SET_M->SET_AH->SET_AM->RUN.
REQ-012 In RUN, each tick SHALL increment seconds 00..59; 59->00 carries to minutes 00..59 in the same cycle; 59->00 carries to hours.
REQ-013 Hours SHALL wrap 23->00 (HOUR_24=1), or 12->01 with pm toggling on 11->12 (HOUR_24=0).
REQ-014 In SET_H/SET_M, seconds SHALL be forced to 00 and held; ticks SHALL NOT advance time; the prescaler SHALL keep counting.
REQ-015 key_inc_h SHALL increment hours only in SET_H/SET_AH; key_inc_m increments minutes only in SET_M/SET_AM; wraps as REQ-012/013, no carry, other fields unchanged.
REQ-016 key_mode and an inc key in the same cycle: mode transition wins, inc ignored.
REQ-017 Increments SHALL be performed on BCD digits directly; outputs update the cycle after the causing event (latency 1).
REQ-018 Alarm SHALL start ringing on the RUN tick where time becomes alarm_h:alarm_m:00 and ring for ALARM_SECS ticks.
REQ-019 Any key pulse while ringing SHALL clear alarm_on next cycle and be otherwise consumed (no mode change, no increment).
REQ-020 Leaving RUN SHALL cancel a ringing alarm.

Reset
REQ-021 On rst: prescaler 0, time 00:00:00 (HOUR_24=1) or 12:00:00 pm=0 (HOUR_24=0), alarm 00:00 / 12:00, state RUN, tick_1hz 0, alarm_on 0.
REQ-022 rst SHALL override all simultaneous key and tick events, including mid-ring.

Configuration
REQ-023 Macro RTC_ALARM_EN SHALL compile in alarm registers, SET_AH/SET_AM states and ring logic.
REQ-024 Without RTC_ALARM_EN: SET_M advances to RUN, alarm_on tied 0, REQ-018..020 absent, ports unchanged.

Structure
REQ-025 Shared package rtc_pkg SHALL hold the state encoding enum and BCD limit constants (59, 23, 12).
REQ-026 One sub-module bcd_cnt (BCD digit-pair counter with configurable min/max, inc, carry out) SHALL be instantiated per field.

Verification
REQ-027 CLK_DIV=4: tick_1hz every 4th cycle; 23:59:59 + tick -> 00:00:00 same update.
REQ-028 HOUR_24=0: 11:59:59 pm=0 + tick -> 12:00:00 pm=1; 12:59:59 + tick -> 01:00:00.
REQ-029 key_mode once, key_inc_h x25 from 00 -> hour 01, seconds 00, minutes unchanged; ticks ignored.
REQ-030 key_mode and key_inc_m same cycle in RUN -> state SET_H, minutes unchanged.
REQ-031 RTC_ALARM_EN, alarm 00:01, ALARM_SECS=3: at 00:01:00 alarm_on=1 for 3 ticks; key pulse on 2nd tick clears it.
REQ-032 rst asserted mid-ring in SET_M -> next cycle all outputs at REQ-021 values.

Source files
------------

// File: rtl/rtc_pkg.sv
// rtc_pkg: state encoding, BCD field limits and the BCD digit-pair increment
// shared by the real-time clock core and its field counters.
package rtc_pkg;

   typedef enum logic [2:0] {
      ST_RUN    = 3'd0,
      ST_SET_H  = 3'd1,
      ST_SET_M  = 3'd2,
      ST_SET_AH = 3'd3,
      ST_SET_AM = 3'd4
   } state_t;

   localparam logic [7:0] BCD_00 = 8'h00;
   localparam logic [7:0] BCD_01 = 8'h01;
   localparam logic [7:0] BCD_11 = 8'h11;
   localparam logic [7:0] BCD_12 = 8'h12;
   localparam logic [7:0] BCD_23 = 8'h23;
   localparam logic [7:0] BCD_59 = 8'h59;

   // Digit-wise +1 without range wrap; callers handle the field maximum.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

endpackage

// File: rtl/bcd_cnt.sv
// bcd_cnt: two-digit BCD field counter wrapping MAX -> MIN, with synchronous
// clear to MIN and a carry flag raised on the wrapping increment.
module bcd_cnt
   import rtc_pkg::*;
#(
   parameter logic [7:0] MIN     = BCD_00,
   parameter logic [7:0] MAX     = BCD_59,
   parameter logic [7:0] RST_VAL = BCD_00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clr,
   output logic [7:0] value,
   output logic [7:0] nxt,
   output logic       carry
);

   always_comb begin
      // NOTE: default assignment first, so no path through the block infers a latch.
      nxt = value;
      if (clr)      nxt = MIN;
      else if (inc) nxt = (value == MAX) ? MIN : bcd_inc(value);
   end

   assign carry = inc & ~clr & (value == MAX);

   // NOTE: non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) value <= RST_VAL;
      else     value <= nxt;
   end

endmodule

// File: rtl/rtc_clock_core.sv
// rtc_clock_core: BCD time-of-day clock with 1 Hz prescaler and key-driven setting.
// Define RTC_ALARM_EN to build in the alarm registers, SET_AH/SET_AM and ring logic.
module rtc_clock_core
   import rtc_pkg::*;
#(
   parameter int CLK_DIV    = 50_000_000,
   parameter int HOUR_24    = 1,
   parameter int ALARM_SECS = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_mode,
   input  logic       key_inc_h,
   input  logic       key_inc_m,
   output logic [7:0] sec_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] hour_bcd,
   output logic       pm,
   output logic       tick_1hz,
   output logic [2:0] state,
   output logic       alarm_on
);

   localparam int         PW       = $clog2(CLK_DIV);
   localparam logic [7:0] HOUR_MIN = (HOUR_24 != 0) ? BCD_00 : BCD_01;
   localparam logic [7:0] HOUR_MAX = (HOUR_24 != 0) ? BCD_23 : BCD_12;
   localparam logic [7:0] HOUR_RST = (HOUR_24 != 0) ? BCD_00 : BCD_12;

   logic [PW-1:0] presc;
   state_t        st;
   logic          consumed, mode_go, inc_h_go, inc_m_go, adv, sec_clr;
   logic          min_inc, hour_inc, sec_carry, min_carry, hour_carry;
   logic [7:0]    sec_nxt, min_nxt, hour_nxt;

   assign tick_1hz = (presc == PW'(CLK_DIV - 1));

   // NOTE: reset is synchronous, so it only takes effect on a clk edge.
   always_ff @(posedge clk) begin
      if (rst || tick_1hz) presc <= '0;
      else                 presc <= presc + 1'b1;
   end

   // A mode press outranks an increment in the same cycle; a key that silences
   // a ringing alarm does nothing else.
   assign mode_go  = key_mode & ~consumed;
   assign inc_h_go = key_inc_h & ~key_mode & ~consumed;
   assign inc_m_go = key_inc_m & ~key_mode & ~consumed;
   assign adv      = tick_1hz & (st == ST_RUN) & ~mode_go;
   assign sec_clr  = (st == ST_SET_H) | (st == ST_SET_M) | ((st == ST_RUN) & mode_go);
   assign min_inc  = (adv & sec_carry) | ((st == ST_SET_M) & inc_m_go);
   assign hour_inc = (adv & min_carry) | ((st == ST_SET_H) & inc_h_go);

   bcd_cnt #(.MIN(BCD_00), .MAX(BCD_59), .RST_VAL(BCD_00)) u_sec (
      .clk(clk), .rst(rst), .inc(adv), .clr(sec_clr),
      .value(sec_bcd), .nxt(sec_nxt), .carry(sec_carry)
   );

   bcd_cnt #(.MIN(BCD_00), .MAX(BCD_59), .RST_VAL(BCD_00)) u_min (
      .clk(clk), .rst(rst), .inc(min_inc), .clr(1'b0),
      .value(min_bcd), .nxt(min_nxt), .carry(min_carry)
   );

   bcd_cnt #(.MIN(HOUR_MIN), .MAX(HOUR_MAX), .RST_VAL(HOUR_RST)) u_hour (
      .clk(clk), .rst(rst), .inc(hour_inc), .clr(1'b0),
      .value(hour_bcd), .nxt(hour_nxt), .carry(hour_carry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         st <= ST_RUN;
         pm <= 1'b0;
      end else begin
         if (mode_go) begin
            case (st)
               ST_RUN:    st <= ST_SET_H;
               ST_SET_H:  st <= ST_SET_M;
`ifdef RTC_ALARM_EN
               ST_SET_M:  st <= ST_SET_AH;
               ST_SET_AH: st <= ST_SET_AM;
`endif
               default:   st <= ST_RUN;
            endcase
         end
         if ((HOUR_24 == 0) && hour_inc && (hour_bcd == BCD_11)) pm <= ~pm;
      end
   end

   assign state = st;

`ifdef RTC_ALARM_EN
   logic [7:0] alarm_h, alarm_m, ah_nxt, am_nxt;
   logic       ah_carry, am_carry, ring_start, unused_sink;
   logic [5:0] ring_left;

   assign consumed   = alarm_on & (key_mode | key_inc_h | key_inc_m);
   assign ring_start = adv & (sec_nxt == BCD_00) & (min_nxt == alarm_m) & (hour_nxt == alarm_h);

   bcd_cnt #(.MIN(HOUR_MIN), .MAX(HOUR_MAX), .RST_VAL(HOUR_RST)) u_alarm_h (
      .clk(clk), .rst(rst), .inc((st == ST_SET_AH) & inc_h_go), .clr(1'b0),
      .value(alarm_h), .nxt(ah_nxt), .carry(ah_carry)
   );

   bcd_cnt #(.MIN(BCD_00), .MAX(BCD_59), .RST_VAL(BCD_00)) u_alarm_m (
      .clk(clk), .rst(rst), .inc((st == ST_SET_AM) & inc_m_go), .clr(1'b0),
      .value(alarm_m), .nxt(am_nxt), .carry(am_carry)
   );

   // ring_left counts the ticks still to ring after the one that started it.
   always_ff @(posedge clk) begin
      if (rst) begin
         alarm_on  <= 1'b0;
         ring_left <= '0;
      end else if (consumed || (st != ST_RUN)) begin
         alarm_on <= 1'b0;
      end else if (ring_start) begin
         alarm_on  <= 1'b1;
         ring_left <= 6'(ALARM_SECS - 1);
      end else if (alarm_on && adv) begin
         if (ring_left == '0) alarm_on  <= 1'b0;
         else                 ring_left <= ring_left - 1'b1;
      end
   end

   assign unused_sink = ^{ah_nxt, am_nxt, ah_carry, am_carry, hour_carry};
`else
   logic unused_sink;

   assign consumed    = 1'b0;
   assign alarm_on    = 1'b0;
   assign unused_sink = ^{sec_nxt, min_nxt, hour_nxt, hour_carry, (ALARM_SECS > 0)};
`endif

endmodule

// File: tb/tb_rtc_clock_core.sv
// tb_rtc_clock_core: directed bench for a 24 h and a 12 h clock core at CLK_DIV=4;
// alarm scenarios are included when RTC_ALARM_EN is defined.
module tb_rtc_clock_core;

   localparam logic [2:0] K_MODE = 3'b100;
   localparam logic [2:0] K_H    = 3'b010;
   localparam logic [2:0] K_M    = 3'b001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, key_mode, key_inc_h, key_inc_m;
   logic [7:0] sec_bcd, min_bcd, hour_bcd;
   logic       pm, tick_1hz, alarm_on;
   logic [2:0] state;
   logic       rst12, mode12, inch12, incm12;
   logic [7:0] sec12, min12, hour12;
   logic       pm12, tick12, alarm12;
   logic [2:0] state12;
   logic [23:0] tm, tm12;

   int n_cmp = 0;
   int n_bad = 0;

   assign tm   = {hour_bcd, min_bcd, sec_bcd};
   assign tm12 = {hour12, min12, sec12};

   rtc_clock_core #(.CLK_DIV(4), .HOUR_24(1), .ALARM_SECS(3)) dut (
      .clk(clk), .rst(rst), .key_mode(key_mode), .key_inc_h(key_inc_h), .key_inc_m(key_inc_m),
      .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd), .pm(pm),
      .tick_1hz(tick_1hz), .state(state), .alarm_on(alarm_on)
   );

   rtc_clock_core #(.CLK_DIV(4), .HOUR_24(0), .ALARM_SECS(3)) dut12 (
      .clk(clk), .rst(rst12), .key_mode(mode12), .key_inc_h(inch12), .key_inc_m(incm12),
      .sec_bcd(sec12), .min_bcd(min12), .hour_bcd(hour12), .pm(pm12),
      .tick_1hz(tick12), .state(state12), .alarm_on(alarm12)
   );

   task automatic do_reset;
      rst = 1'b1; rst12 = 1'b1;
      {key_mode, key_inc_h, key_inc_m} = 3'b000;
      {mode12, inch12, incm12} = 3'b000;
      repeat (2) @(negedge clk);
      rst = 1'b0; rst12 = 1'b0;
   endtask

   // One-cycle key pulse; returns at the negedge where its effect is visible.
   task automatic press(input logic [2:0] k, input bit s12);
      if (s12) {mode12, inch12, incm12} = k;
      else     {key_mode, key_inc_h, key_inc_m} = k;
      @(negedge clk);
      {mode12, inch12, incm12} = 3'b000;
      {key_mode, key_inc_h, key_inc_m} = 3'b000;
   endtask

   task automatic tick_wait(input bit s12);
      int k;
      k = 0;
      while (((s12 ? tick12 : tick_1hz) !== 1'b1) && (k < 16)) begin
         @(negedge clk);
         k++;
      end
      if (k >= 16) begin
         n_cmp++; n_bad++;
         $display("FAIL tick_timeout: no tick within %0d cycles, required within 4", k);
      end
   endtask

   task automatic run_ticks(input int n, input bit s12);
      repeat (n) begin
         tick_wait(s12);
         @(negedge clk);
      end
   endtask

   task automatic to_run_from_set_m(input bit s12);
      press(K_MODE, s12);
`ifdef RTC_ALARM_EN
      press(K_MODE, s12);
      press(K_MODE, s12);
`endif
   endtask

   task automatic test_reset;
      do_reset();
      n_cmp++; if (tm !== 24'h000000) begin n_bad++; $display("FAIL reset_time: got %h want 000000", tm); end
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
      n_cmp++; if (tick_1hz !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b want 0", tick_1hz); end
      n_cmp++; if (alarm_on !== 1'b0) begin n_bad++; $display("FAIL reset_alarm: got %b want 0", alarm_on); end
      n_cmp++; if (pm !== 1'b0) begin n_bad++; $display("FAIL reset_pm24: got %b want 0", pm); end
      n_cmp++; if (tm12 !== 24'h120000) begin n_bad++; $display("FAIL reset_time12: got %h want 120000", tm12); end
      n_cmp++; if (pm12 !== 1'b0) begin n_bad++; $display("FAIL reset_pm12: got %b want 0", pm12); end
   endtask

   task automatic test_tick_period;
      int k;
      do_reset();
      k = 0;
      while ((tick_1hz !== 1'b1) && (k < 16)) begin @(negedge clk); k++; end
      n_cmp++; if (k != 3) begin n_bad++; $display("FAIL first_tick: got %0d cycles want 3", k); end
      @(negedge clk);
      n_cmp++; if (tick_1hz !== 1'b0) begin n_bad++; $display("FAIL tick_width: got %b want 0", tick_1hz); end
      k = 1;
      while ((tick_1hz !== 1'b1) && (k < 16)) begin @(negedge clk); k++; end
      n_cmp++; if (k != 4) begin n_bad++; $display("FAIL tick_period: got %0d cycles want 4", k); end
      n_cmp++; if (sec_bcd !== 8'h01) begin n_bad++; $display("FAIL first_second: got %h want 01", sec_bcd); end
   endtask

   task automatic test_mode_cycle;
`ifdef RTC_ALARM_EN
      logic [2:0] seq [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
`else
      logic [2:0] seq [3] = '{3'd1, 3'd2, 3'd0};
`endif
      do_reset();
      foreach (seq[i]) begin
         press(K_MODE, 1'b0);
         n_cmp++; if (state !== seq[i]) begin n_bad++; $display("FAIL mode_seq[%0d]: got %0d want %0d", i, state, seq[i]); end
      end
   endtask

   task automatic test_set_hour;
      do_reset();
      run_ticks(3, 1'b0);
      n_cmp++; if (tm !== 24'h000003) begin n_bad++; $display("FAIL run_3s: got %h want 000003", tm); end
      press(K_MODE, 1'b0);
      n_cmp++; if ({state, tm} !== {3'd1, 24'h000000}) begin n_bad++; $display("FAIL enter_set_h: got %0d/%h want 1/000000", state, tm); end
      press(K_M, 1'b0);
      repeat (25) press(K_H, 1'b0);
      run_ticks(2, 1'b0);
      n_cmp++; if (tm !== 24'h010000) begin n_bad++; $display("FAIL inc_h_x25: got %h want 010000", tm); end
      press(K_MODE, 1'b0);
      repeat (3) press(K_M, 1'b0);
      press(K_H, 1'b0);
      n_cmp++; if ({state, tm} !== {3'd2, 24'h010300}) begin n_bad++; $display("FAIL inc_m_x3: got %0d/%h want 2/010300", state, tm); end
   endtask

   task automatic test_mode_and_inc;
      do_reset();
      press(K_MODE | K_M, 1'b0);
      n_cmp++; if ({state, tm} !== {3'd1, 24'h000000}) begin n_bad++; $display("FAIL mode_inc_m: got %0d/%h want 1/000000", state, tm); end
      press(K_MODE | K_H, 1'b0);
      n_cmp++; if ({state, tm} !== {3'd2, 24'h000000}) begin n_bad++; $display("FAIL mode_inc_h: got %0d/%h want 2/000000", state, tm); end
   endtask

   task automatic test_rollover_24;
      do_reset();
      press(K_MODE, 1'b0);
      repeat (23) press(K_H, 1'b0);
      press(K_MODE, 1'b0);
      repeat (59) press(K_M, 1'b0);
      to_run_from_set_m(1'b0);
      n_cmp++; if ({state, tm} !== {3'd0, 24'h235900}) begin n_bad++; $display("FAIL set_2359: got %0d/%h want 0/235900", state, tm); end
      run_ticks(59, 1'b0);
      n_cmp++; if (tm !== 24'h235959) begin n_bad++; $display("FAIL reach_235959: got %h want 235959", tm); end
      run_ticks(1, 1'b0);
      n_cmp++; if (tm !== 24'h000000) begin n_bad++; $display("FAIL midnight: got %h want 000000", tm); end
`ifdef RTC_ALARM_EN
      n_cmp++; if (alarm_on !== 1'b1) begin n_bad++; $display("FAIL midnight_alarm: got %b want 1", alarm_on); end
`endif
   endtask

   task automatic test_12h;
      do_reset();
      press(K_MODE, 1'b1);
      repeat (11) press(K_H, 1'b1);
      press(K_MODE, 1'b1);
      repeat (59) press(K_M, 1'b1);
      to_run_from_set_m(1'b1);
      run_ticks(59, 1'b1);
      n_cmp++; if ({pm12, tm12} !== {1'b0, 24'h115959}) begin n_bad++; $display("FAIL am_115959: got %b/%h want 0/115959", pm12, tm12); end
      run_ticks(1, 1'b1);
      n_cmp++; if ({pm12, tm12} !== {1'b1, 24'h120000}) begin n_bad++; $display("FAIL noon: got %b/%h want 1/120000", pm12, tm12); end
`ifdef RTC_ALARM_EN
      n_cmp++; if (alarm12 !== 1'b1) begin n_bad++; $display("FAIL noon_alarm: got %b want 1", alarm12); end
      press(K_H, 1'b1);
      n_cmp++; if ({alarm12, state12, hour12} !== {1'b0, 3'd0, 8'h12}) begin n_bad++; $display("FAIL consume_inc_h: got %b/%0d/%h want 0/0/12", alarm12, state12, hour12); end
`else
      n_cmp++; if (alarm12 !== 1'b0) begin n_bad++; $display("FAIL alarm_tied: got %b want 0", alarm12); end
`endif
      press(K_MODE, 1'b1);
      press(K_MODE, 1'b1);
      repeat (59) press(K_M, 1'b1);
      to_run_from_set_m(1'b1);
      run_ticks(59, 1'b1);
      n_cmp++; if ({pm12, tm12} !== {1'b1, 24'h125959}) begin n_bad++; $display("FAIL pm_125959: got %b/%h want 1/125959", pm12, tm12); end
      run_ticks(1, 1'b1);
      n_cmp++; if ({pm12, tm12} !== {1'b1, 24'h010000}) begin n_bad++; $display("FAIL wrap_0100: got %b/%h want 1/010000", pm12, tm12); end
   endtask

   task automatic test_reset_override;
      int k;
      do_reset();
      press(K_MODE, 1'b0);
      press(K_MODE, 1'b0);
      repeat (5) press(K_M, 1'b0);
      {rst, key_mode, key_inc_m} = 3'b111;
      @(negedge clk);
      {rst, key_mode, key_inc_m} = 3'b000;
      n_cmp++; if ({state, tm, pm, alarm_on, tick_1hz} !== {3'd0, 24'h000000, 3'b000}) begin
         n_bad++; $display("FAIL rst_in_set_m: got %0d/%h/%b%b%b want 0/000000/000", state, tm, pm, alarm_on, tick_1hz);
      end
      k = 0;
      while ((tick_1hz !== 1'b1) && (k < 16)) begin @(negedge clk); k++; end
      n_cmp++; if (k != 3) begin n_bad++; $display("FAIL rst_prescaler: got %0d cycles want 3", k); end
   endtask

`ifdef RTC_ALARM_EN
   // Alarm 00:01 from reset, then run to 00:01:00 where ringing begins.
   task automatic alarm_to_ring;
      do_reset();
      repeat (4) press(K_MODE, 1'b0);
      press(K_M, 1'b0);
      press(K_MODE, 1'b0);
      run_ticks(60, 1'b0);
   endtask

   task automatic test_alarm;
      do_reset();
      repeat (4) press(K_MODE, 1'b0);
      press(K_M, 1'b0);
      n_cmp++; if ({state, tm} !== {3'd4, 24'h000000}) begin n_bad++; $display("FAIL set_alarm_m: got %0d/%h want 4/000000", state, tm); end
      press(K_MODE, 1'b0);
      run_ticks(59, 1'b0);
      n_cmp++; if (alarm_on !== 1'b0) begin n_bad++; $display("FAIL pre_alarm: got %b want 0", alarm_on); end
      run_ticks(1, 1'b0);
      n_cmp++; if ({alarm_on, tm} !== {1'b1, 24'h000100}) begin n_bad++; $display("FAIL ring_start: got %b/%h want 1/000100", alarm_on, tm); end
      run_ticks(2, 1'b0);
      n_cmp++; if ({alarm_on, tm} !== {1'b1, 24'h000102}) begin n_bad++; $display("FAIL ring_hold: got %b/%h want 1/000102", alarm_on, tm); end
      run_ticks(1, 1'b0);
      n_cmp++; if ({alarm_on, tm} !== {1'b0, 24'h000103}) begin n_bad++; $display("FAIL ring_end: got %b/%h want 0/000103", alarm_on, tm); end

      alarm_to_ring();
      tick_wait(1'b0);
      key_mode = 1'b1;
      @(negedge clk);
      key_mode = 1'b0;
      n_cmp++; if ({alarm_on, state, tm} !== {1'b0, 3'd0, 24'h000101}) begin
         n_bad++; $display("FAIL key_clear: got %b/%0d/%h want 0/0/000101", alarm_on, state, tm);
      end

      alarm_to_ring();
      run_ticks(1, 1'b0);
      tick_wait(1'b0);
      {rst, key_mode, key_inc_h} = 3'b111;
      @(negedge clk);
      {rst, key_mode, key_inc_h} = 3'b000;
      n_cmp++; if ({state, tm, pm, alarm_on, tick_1hz} !== {3'd0, 24'h000000, 3'b000}) begin
         n_bad++; $display("FAIL rst_mid_ring: got %0d/%h/%b%b%b want 0/000000/000", state, tm, pm, alarm_on, tick_1hz);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_tick_period();
      test_mode_cycle();
      test_set_hour();
      test_mode_and_inc();
      test_rollover_24();
      test_12h();
      test_reset_override();
`ifdef RTC_ALARM_EN
      test_alarm();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
